// File: rtl/toggle_cover_pkg.sv
// Shared constants and types for the toggle-coverage report scheduler.
package toggle_cover_pkg;

  // Total cover points in the instrumented design's toggle space
  localparam longint unsigned COVER_TOTAL = 64'd8065;

  // Default number of toggle bits per group
  localparam int unsigned DEFAULT_GROUP_W = 8;

  // Absolute cover index carried on the report stream
  typedef logic [63:0] cover_idx_t;

endpackage : toggle_cover_pkg

// File: rtl/toggle_cover_prio_enc.sv
// Lowest-set-bit priority encoder: any=1 when req is non-zero, sel=index of lowest set bit.
module toggle_cover_prio_enc #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req,
  output logic                 any,
  output logic [$clog2(N)-1:0] sel
);

  localparam int unsigned SEL_W = $clog2(N);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    any = |req;
    sel = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) sel = SEL_W'(i);
    end
  end

endmodule : toggle_cover_prio_enc

// File: rtl/toggle_cover_sched.sv
// Deduplicating toggle-coverage scheduler: remembers fired points and serialises each
// first-time hit onto a single valid/ready report stream with an absolute cover index.
module toggle_cover_sched
  import toggle_cover_pkg::*;
#(
  parameter longint unsigned COVER_INDEX = 0,
  parameter int unsigned     GROUP_W     = DEFAULT_GROUP_W,
  parameter int unsigned     N_GROUPS    = 4
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     enable,
  input  logic                                     clear,
  input  logic [GROUP_W*N_GROUPS-1:0]              valid,
  input  logic                                     report_ready,
  output logic                                     report_valid,
  output logic [63:0]                              report_index,
  output logic [$clog2(GROUP_W*N_GROUPS+1)-1:0]    hit_count
);

  localparam int unsigned N     = GROUP_W * N_GROUPS;
  localparam int unsigned SEL_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(N + 1);

  // The window of points handled here must fit inside the design's toggle space
  if (COVER_INDEX + longint'(N) > COVER_TOTAL) begin : g_range_err
    $error("toggle_cover_sched: COVER_INDEX + N exceeds COVER_TOTAL");
  end

  logic [N-1:0]     seen_q, seen_d;
  logic [N-1:0]     pending_q, pending_d;
  logic             report_valid_q, report_valid_d;
  cover_idx_t       report_index_q, report_index_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;

  logic [N-1:0]     new_hits;
  logic             handshake;
  logic             load;
  logic             pend_any;
  logic [SEL_W-1:0] pend_sel;

  toggle_cover_prio_enc #(
    .N (N)
  ) u_prio_enc (
    .req (pending_q),
    .any (pend_any),
    .sel (pend_sel)
  );

  // Next-state: capture new hits, refill the output register, count handshakes, apply clear
  always_comb begin
    new_hits       = (enable && !clear) ? (valid & ~seen_q) : '0;
    handshake      = report_valid_q && report_ready;
    load           = !report_valid_q || report_ready;

    seen_d         = seen_q | new_hits;
    pending_d      = pending_q | new_hits;
    report_valid_d = report_valid_q;
    report_index_d = report_index_q;
    hit_count_d    = hit_count_q;

    if (handshake && (hit_count_q != CNT_W'(N))) begin
      hit_count_d = hit_count_q + CNT_W'(1);
    end

    // Clear forgets pending points, so nothing new is loaded in that cycle
    if (load) begin
      if (pend_any && !clear) begin
        report_valid_d      = 1'b1;
        report_index_d      = cover_idx_t'(COVER_INDEX) + cover_idx_t'(pend_sel);
        pending_d[pend_sel] = 1'b0;
      end else begin
        report_valid_d      = 1'b0;
      end
    end

    // An in-flight report survives clear; only the memory and the count are wiped
    if (clear) begin
      seen_d      = '0;
      pending_d   = '0;
      hit_count_d = '0;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      seen_q         <= '0;
      pending_q      <= '0;
      report_valid_q <= 1'b0;
      report_index_q <= '0;
      hit_count_q    <= '0;
    end else begin
      seen_q         <= seen_d;
      pending_q      <= pending_d;
      report_valid_q <= report_valid_d;
      report_index_q <= report_index_d;
      hit_count_q    <= hit_count_d;
    end
  end

  assign report_valid = report_valid_q;
  assign report_index = report_index_q;
  assign hit_count    = hit_count_q;

endmodule : toggle_cover_sched
